// File: rtl/mips_processor_pkg.sv
// rtl/mips_processor_pkg.sv - shared opcodes, function codes, ALU ops and register indices
package mips_processor_pkg;

    localparam int IMEM_BYTES = 1024;
    localparam int DMEM_BYTES = 1024;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b,
                           OP_JPC   = 6'h3e;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                           F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND  = 6'h24, F_OR   = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT  = 6'h2a, F_SLTU = 6'h2b;

    localparam logic [4:0] REG_ZERO = 5'd0, REG_T0 = 5'd8, REG_T1 = 5'd9,
                           REG_S0 = 5'd16, REG_S1 = 5'd17, REG_RA = 5'd31;

    localparam logic [2:0] PC_SEQ = 3'd0, PC_BRANCH = 3'd1, PC_JUMP = 3'd2,
                           PC_JPC = 3'd3, PC_JR = 3'd4;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_t;

    // Shifts operate on b (the rt operand) by the instruction's shamt field.
    function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b,
                                        logic [4:0] shamt);
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_NOR:   return ~(a | b);
            ALU_SLT:   return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  return {31'd0, a < b};
            ALU_SLL:   return b << shamt;
            ALU_SRL:   return b >> shamt;
            ALU_SRA:   return $signed(b) >>> shamt;
            ALU_PASSB: return b;
            default:   return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_processor_ifu.sv
// rtl/mips_processor_ifu.sv - instruction byte storage, instruction memory and fetch unit
module mips_processor_storage
    import mips_processor_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  waddr,
    input  logic [7:0]  wdata,
    input  logic [9:0]  addr,
    output logic [31:0] word
);
    logic [7:0] bytes [IMEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) bytes[waddr] <= wdata;
    end

    assign word = {bytes[addr], bytes[addr + 10'd1], bytes[addr + 10'd2], bytes[addr + 10'd3]};
endmodule

module mips_processor_imemory (
    input  logic        clk,
    input  logic [9:0]  addr,
    output logic [31:0] instr
);
    // Program contents are preloaded through the hierarchy; the write port stays idle.
    mips_processor_storage storage (
        .clk(clk), .we(1'b0), .waddr(10'd0), .wdata(8'd0), .addr(addr), .word(instr)
    );
endmodule

module mips_processor_ifu
    import mips_processor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr
);
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic [31:0] jpc_off;

    mips_processor_imemory imemory (.clk(clk), .addr(pc[9:0]), .instr(instr));

    assign pc4     = pc + 32'd4;
    assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jpc_off = {{4{instr[25]}}, instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc4;
        case (pc_sel)
            PC_BRANCH: next_pc = pc4 + br_off;
            PC_JUMP:   next_pc = {pc4[31:28], instr[25:0], 2'b00};
            PC_JPC:    next_pc = pc4 + jpc_off;
            PC_JR:     next_pc = jr_target;
            default:   next_pc = pc4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= 32'd0;
        else       pc <= next_pc;
    end
endmodule

// File: rtl/mips_processor_regfile.sv
// rtl/mips_processor_regfile.sv - 32x32 register file, two combinational reads, one write
module mips_processor_regfile
    import mips_processor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (we && wa != REG_ZERO) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == REG_ZERO) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == REG_ZERO) ? 32'd0 : registers[ra2];
endmodule

// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle MIPS-subset CPU: decode, ALU, data memory, commit
module mips_processor
    import mips_processor_pkg::*;
(
    input  logic clk,
    input  logic reset
);
    logic [31:0] pc, pc4, instr;
    logic [31:0] rs_val, rt_val, b_val, alu_y, load_word, wd;
    logic [31:0] sext_imm, imm_val;
    logic [9:0]  daddr;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wa;
    logic [2:0]  pc_sel;
    logic        use_imm, reg_we, mem_we, mem_rd, link;
    alu_op_t     alu_op;
    logic [7:0]  dmem [DMEM_BYTES];

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign sext_imm = {{16{instr[15]}}, instr[15:0]};

    mips_processor_ifu IFU (
        .clk(clk), .reset(reset), .pc_sel(pc_sel), .jr_target(rs_val),
        .pc(pc), .pc4(pc4), .instr(instr)
    );

    mips_processor_regfile registers (
        .clk(clk), .reset(reset), .we(reg_we), .ra1(rs), .ra2(rt),
        .wa(wa), .wd(wd), .rd1(rs_val), .rd2(rt_val)
    );

    // Undefined opcodes and functs fall through the defaults and retire as nops.
    always_comb begin
        alu_op  = ALU_ADD;
        use_imm = 1'b0;
        imm_val = sext_imm;
        reg_we  = 1'b0;
        wa      = rd;
        mem_we  = 1'b0;
        mem_rd  = 1'b0;
        link    = 1'b0;
        pc_sel  = PC_SEQ;
        case (op)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    F_SLTU: alu_op = ALU_SLTU;
                    F_SLL:  alu_op = ALU_SLL;
                    F_SRL:  alu_op = ALU_SRL;
                    F_SRA:  alu_op = ALU_SRA;
                    F_JR: begin
                        reg_we = 1'b0;
                        pc_sel = PC_JR;
                    end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                wa      = rt;
                case (op)
                    OP_SLTI:  alu_op = ALU_SLT;
                    OP_SLTIU: alu_op = ALU_SLTU;
                    OP_ANDI:  begin alu_op = ALU_AND; imm_val = {16'd0, instr[15:0]}; end
                    OP_ORI:   begin alu_op = ALU_OR;  imm_val = {16'd0, instr[15:0]}; end
                    OP_XORI:  begin alu_op = ALU_XOR; imm_val = {16'd0, instr[15:0]}; end
                    OP_LUI:   begin alu_op = ALU_PASSB; imm_val = {instr[15:0], 16'd0}; end
                    default:  alu_op = ALU_ADD;
                endcase
            end
            OP_LW: begin
                use_imm = 1'b1;
                reg_we  = 1'b1;
                wa      = rt;
                mem_rd  = 1'b1;
            end
            OP_SW: begin
                use_imm = 1'b1;
                mem_we  = 1'b1;
            end
            OP_BEQ: if (rs_val == rt_val) pc_sel = PC_BRANCH;
            OP_BNE: if (rs_val != rt_val) pc_sel = PC_BRANCH;
            OP_J:   pc_sel = PC_JUMP;
            OP_JAL: begin
                pc_sel = PC_JUMP;
                reg_we = 1'b1;
                wa     = REG_RA;
                link   = 1'b1;
            end
            OP_JPC: pc_sel = PC_JPC;
            default: ;
        endcase
    end

    assign b_val = use_imm ? imm_val : rt_val;
    assign alu_y = alu(alu_op, rs_val, b_val, shamt);

    // Accesses are forced word-aligned; the data memory image is big-endian.
    assign daddr     = {alu_y[9:2], 2'b00};
    assign load_word = {dmem[daddr], dmem[{alu_y[9:2], 2'd1}],
                        dmem[{alu_y[9:2], 2'd2}], dmem[{alu_y[9:2], 2'd3}]};
    assign wd        = link ? pc4 : (mem_rd ? load_word : alu_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_BYTES; i++) dmem[i] <= 8'd0;
        end else if (mem_we) begin
            dmem[daddr]               <= rt_val[31:24];
            dmem[{alu_y[9:2], 2'd1}]  <= rt_val[23:16];
            dmem[{alu_y[9:2], 2'd2}]  <= rt_val[15:8];
            dmem[{alu_y[9:2], 2'd3}]  <= rt_val[7:0];
        end
    end
endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - directed-program bench for mips_processor
module tb_mips_processor;
    import mips_processor_pkg::*;

    localparam logic [4:0] T2 = 5'd10, T3 = 5'd11, T4 = 5'd12, T5 = 5'd13, T6 = 5'd14,
                           T7 = 5'd15, S2 = 5'd18, S3 = 5'd19, S4 = 5'd20, S5 = 5'd21;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] prog [$];

    mips_processor dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] target);
        return {op, target};
    endfunction

    function automatic logic [31:0] rf(input logic [4:0] r);
        return dut.registers.registers[r];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_and_run();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.IFU.imemory.storage.bytes[i] = 8'h00;
        foreach (prog[i]) begin
            dut.IFU.imemory.storage.bytes[4*i]     = prog[i][31:24];
            dut.IFU.imemory.storage.bytes[4*i + 1] = prog[i][23:16];
            dut.IFU.imemory.storage.bytes[4*i + 2] = prog[i][15:8];
            dut.IFU.imemory.storage.bytes[4*i + 3] = prog[i][7:0];
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] any_reg;

        #1;
        check("reset_pc", dut.IFU.pc, 32'd0);
        check("reset_s0", rf(REG_S0), 32'd0);

        prog = '{enc_i(OP_ADDI, 5'd0, REG_S0, 16'd1), enc_i(OP_ADDI, 5'd0, REG_S1, 16'd2)};
        load_and_run();
        step(4);
        check("addi_s0", rf(REG_S0), 32'd1);
        check("addi_s1", rf(REG_S1), 32'd2);
        check("addi_t0", rf(REG_T0), 32'd0);
        check("addi_t1", rf(REG_T1), 32'd0);

        prog = '{enc_i(OP_ADDI, 5'd0, REG_S0, 16'd1), enc_i(OP_ADDI, 5'd0, REG_S1, 16'd2),
                 enc_r(REG_T0, REG_S0, REG_T0, 5'd0, F_ADD),
                 enc_r(REG_T1, REG_S1, REG_T1, 5'd0, F_ADD),
                 enc_j(OP_JPC, 26'h3FF_FFFD)};
        load_and_run();
        step(2);
        step(3);
        check("jpc1_t0", rf(REG_T0), 32'd1);
        check("jpc1_t1", rf(REG_T1), 32'd2);
        check("jpc1_pc", dut.IFU.pc, 32'd8);
        step(3);
        check("jpc2_t0", rf(REG_T0), 32'd2);
        check("jpc2_t1", rf(REG_T1), 32'd4);
        step(9);
        check("jpc3_t0", rf(REG_T0), 32'd5);
        check("jpc3_t1", rf(REG_T1), 32'd10);
        check("jpc3_s0", rf(REG_S0), 32'd1);
        check("jpc3_s1", rf(REG_S1), 32'd2);

        step(4);
        #2;
        reset = 1'b1;
        #1;
        check("mid_reset_pc", dut.IFU.pc, 32'd0);
        any_reg = 32'd0;
        for (int r = 0; r < 32; r++) any_reg = any_reg | rf(r[4:0]);
        check("mid_reset_regs", any_reg, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(5);
        check("rerun_t0", rf(REG_T0), 32'd1);
        check("rerun_t1", rf(REG_T1), 32'd2);

        prog = '{enc_i(OP_LUI, 5'd0, T2, 16'h8000), enc_i(OP_ORI, T2, T2, 16'h0001),
                 enc_r(5'd0, T2, T3, 5'd1, F_SRA), enc_r(5'd0, T2, T4, 5'd1, F_SRL),
                 enc_i(OP_ADDI, 5'd0, T5, 16'd1), enc_r(T2, T5, T6, 5'd0, F_SLT),
                 enc_r(T2, T5, T7, 5'd0, F_SLTU), enc_r(T2, 5'd0, S2, 5'd0, F_NOR),
                 enc_r(5'd0, T5, S3, 5'd0, F_SUB), enc_r(5'd0, T5, S4, 5'd31, F_SLL),
                 enc_i(OP_ANDI, S3, S5, 16'hFFFF)};
        load_and_run();
        step(11);
        check("lui_ori", rf(T2), 32'h8000_0001);
        check("sra", rf(T3), 32'hC000_0000);
        check("srl", rf(T4), 32'h4000_0000);
        check("slt", rf(T6), 32'd1);
        check("sltu", rf(T7), 32'd0);
        check("nor", rf(S2), 32'h7FFF_FFFE);
        check("sub_wrap", rf(S3), 32'hFFFF_FFFF);
        check("sll31", rf(S4), 32'h8000_0000);
        check("andi_zext", rf(S5), 32'h0000_FFFF);

        prog = '{enc_i(OP_LUI, 5'd0, REG_T0, 16'hDEAD), enc_i(OP_ORI, REG_T0, REG_T0, 16'hBEEF),
                 enc_i(OP_ADDI, 5'd0, REG_T1, 16'd4), enc_i(OP_SW, REG_T1, REG_T0, 16'd4),
                 enc_i(OP_LW, 5'd0, T2, 16'd8), 32'hFFFF_FFFF};
        load_and_run();
        step(6);
        check("lw_word", rf(T2), 32'hDEAD_BEEF);
        check("mem_b8", {24'd0, dut.dmem[8]}, 32'h0000_00DE);
        check("mem_b9", {24'd0, dut.dmem[9]}, 32'h0000_00AD);
        check("mem_b10", {24'd0, dut.dmem[10]}, 32'h0000_00BE);
        check("mem_b11", {24'd0, dut.dmem[11]}, 32'h0000_00EF);
        check("mem_b12", {24'd0, dut.dmem[12]}, 32'd0);
        check("undef_pc", dut.IFU.pc, 32'd24);
        check("undef_ra", rf(REG_RA), 32'd0);

        prog = '{enc_i(OP_ADDI, 5'd0, REG_T0, 16'd5), enc_i(OP_ADDI, 5'd0, REG_T1, 16'd5),
                 enc_i(OP_BEQ, REG_T0, REG_T1, 16'd1), enc_i(OP_ADDI, 5'd0, REG_S0, 16'd99),
                 enc_i(OP_BNE, REG_T0, REG_T1, 16'd1), enc_i(OP_ADDI, 5'd0, REG_S1, 16'd7),
                 enc_j(OP_JAL, 26'd10), enc_i(OP_ADDI, 5'd0, S2, 16'd3),
                 enc_j(OP_J, 26'd8), 32'd0,
                 enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9), enc_i(OP_ADDI, 5'd0, S3, 16'd4),
                 enc_r(REG_RA, 5'd0, 5'd0, 5'd0, F_JR)};
        load_and_run();
        step(6);
        check("beq_skip", rf(REG_S0), 32'd0);
        check("bne_fall", rf(REG_S1), 32'd7);
        check("jal_ra", rf(REG_RA), 32'd28);
        check("jal_pc", dut.IFU.pc, 32'd40);
        step(6);
        check("zero_reg", rf(5'd0), 32'd0);
        check("sub_body", rf(S3), 32'd4);
        check("jr_return", rf(S2), 32'd3);
        check("j_self_pc", dut.IFU.pc, 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_processor.md
# mips_processor

Single-cycle 32-bit MIPS-subset CPU (RTL module `processor`). Top of the design: fetches one instruction per clock from a byte-addressed instruction memory, decodes, executes and commits it at the next rising edge. Adds the custom PC-relative jump `jpc`. Instance hierarchy is fixed so benches can preload program memory and probe architectural registers directly.

## Interface
- No parameters; sizes come from the shared constants include.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears PC, register file and data memory.
- No other ports. Visibility is through hierarchy:
  - `IFU.imemory.storage.bytes`: 1024 × 8-bit array, loaded by `$readmemb`.
  - `registers.registers`: 32 × 32-bit array.

## Operation
- Instruction word at PC = {bytes[PC], bytes[PC+1], bytes[PC+2], bytes[PC+3]} (big-endian). PC advances by 4 by default.
- R-type (opcode 0): add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr. Destination is rd.
- I-type, destination rt:
  - addi, addiu, slti, sltiu: sign-extended immediate.
  - andi, ori, xori: zero-extended immediate.
  - lui: imm<<16.
  - lw, sw: address = rs + sext(imm), word-aligned, into a 1024-byte big-endian data memory.
- Branches: beq, bne; target = PC+4 + (sext(imm)<<2).
- Jumps: j, jal (jal writes PC+4 to $31); target = {PC+4[31:28], imm26, 2'b00}.
- jpc: opcode 6'b111110, J-format. Target = PC+4 + (sext(imm26)<<2). No register write.
- Arithmetic wraps mod 2^32. Overflow trapping is not implemented: add/addi behave as addu/addiu.
- Register $0 reads 0; writes to it are discarded.
- Undefined opcode/funct executes as a nop (PC+4, no writes).

## Timing
- Reset: PC=0, all 32 registers=0, data memory=0. Instruction memory contents are preserved.
- Exactly one instruction retires per rising edge after reset deasserts. Register write, memory write and PC update all commit on that same edge.
- Register file reads and memory reads are combinational, so a result is visible to the next instruction.
- Taken branch/jump: the new PC takes effect at the committing edge. There are no delay slots.
- Same register as source and destination: the source reads the old value.
- Reset asserted mid-program: state clears immediately, regardless of the clock.
- PC wraps mod 1024 within instruction memory.

## Structure
- Shared constants include (`_const.v`): opcode/funct codes, ALU op codes, and register indices (`REG_S0`=16, `REG_S1`=17, `REG_T0`=8, `REG_T1`=9, etc.).
- Sub-modules:
  - `IFU`: PC register, next-PC mux, `imemory` with inner `storage`.
  - `registers`: 2-read/1-write register file.
  - Control decoder, ALU, data memory.
- The instance names `IFU`, `imemory`, `storage`, `bytes`, `registers` are mandatory.

## Test plan
- Reset, then run a program of addi s0,$0,1; addi s1,$0,2 -> after 4 edges s0=1, s1=2, t0=t1=0.
- jpc loop: loop body add t0,t0,s0; add t1,t1,s1; jpc −3 words -> +3 edges t0=1, t1=2; +3 edges t0=2, t1=4; +9 edges t0=5, t1=10; s0/s1 unchanged.
- ALU: lui/ori build 0x8000_0001 -> sra by 1 gives 0xC000_0000, srl gives 0x4000_0000, slt vs 1 gives 1, sltu gives 0.
- Memory: sw 0xDEADBEEF to address 8, then lw -> register holds 0xDEADBEEF; bytes at 8..11 are DE AD BE EF.
- Control flow:
  - beq taken skips the next instruction; bne not taken falls through.
  - jal writes $31 = PC+4; jr $31 returns.
  - An addi to $0 leaves $0=0.
- Reset pulse asserted mid-loop -> PC=0 and all registers 0 immediately; the program re-executes correctly.
